// File: rtl/matrix_calc_engine_if.sv
// Signal bundle between the control FSM / matrix storage and matrix_calc_engine.
// The engine uses the slave view; the controller side (or a bench) uses master.
interface matrix_calc_engine_if #(
    parameter int DW   = 32,
    parameter int AW   = 8,
    parameter int DIMW = 3
);
    logic            i_start;
    logic [2:0]      i_op_code;
    logic [AW-1:0]   i_op1_addr;
    logic [DIMW-1:0] i_op1_m;
    logic [DIMW-1:0] i_op1_n;
    logic [AW-1:0]   i_op2_addr;
    logic [DIMW-1:0] i_op2_m;
    logic [DIMW-1:0] i_op2_n;
    logic [DW-1:0]   i_scalar;
    logic [AW-1:0]   i_res_addr;
    logic            o_busy;
    logic            o_done;
    logic            o_err;
    logic [DIMW-1:0] o_res_m;
    logic [DIMW-1:0] o_res_n;
    logic            o_rd_en;
    logic [AW-1:0]   o_rd_addr;
    logic [DW-1:0]   i_rd_data;
    logic            o_we;
    logic [AW-1:0]   o_waddr;
    logic [DW-1:0]   o_wdata;

    modport slave (
        input  i_start, i_op_code, i_op1_addr, i_op1_m, i_op1_n,
               i_op2_addr, i_op2_m, i_op2_n, i_scalar, i_res_addr, i_rd_data,
        output o_busy, o_done, o_err, o_res_m, o_res_n,
               o_rd_en, o_rd_addr, o_we, o_waddr, o_wdata
    );

    modport master (
        output i_start, i_op_code, i_op1_addr, i_op1_m, i_op1_n,
               i_op2_addr, i_op2_m, i_op2_n, i_scalar, i_res_addr, i_rd_data,
        input  o_busy, o_done, o_err, o_res_m, o_res_n,
               o_rd_en, o_rd_addr, o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/matrix_calc_engine.sv
// Matrix engine: transpose, add, scalar multiply and matrix multiply over small
// row-major matrices held in internal buffers, loaded from and written back to storage.
module matrix_calc_engine #(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int MAX_DIM = 5,
    parameter int DIMW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    matrix_calc_engine_if.slave bus
);
    localparam int NMAX = MAX_DIM * MAX_DIM;
    localparam int CW   = $clog2(NMAX + 1);

    localparam logic [2:0]      OP_TRN  = 3'd0;
    localparam logic [2:0]      OP_ADD  = 3'd1;
    localparam logic [2:0]      OP_SMUL = 3'd2;
    localparam logic [2:0]      OP_MMUL = 3'd3;
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [DIMW-1:0] D_ONE   = DIMW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [AW-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, r_addr_q, r_addr_d;
    logic [DIMW-1:0] m1_q, m1_d, n1_q, n1_d, m2_q, m2_d, n2_q, n2_d;
    logic [DW-1:0]   scalar_q, scalar_d;
    logic            err_q, err_d;
    logic [DIMW-1:0] res_m_q, res_m_d, res_n_q, res_n_d;
    logic [CW-1:0]   na_q, na_d, nb_q, nb_d, nr_q, nr_d, cnt_q, cnt_d;
    logic [DIMW-1:0] row_q, row_d, col_q, col_d, k_q, k_d;

    logic [DW-1:0]   buf_a [NMAX];
    logic [DW-1:0]   buf_b [NMAX];
    logic [DW-1:0]   buf_r [NMAX];
    logic [DW-1:0]   acc_q;

    logic            chk_err;
    logic [DIMW-1:0] rm, rn;
    logic [DW-1:0]   prod, acc_nx, elem_val;
    logic            last_k, calc_wr;
    logic            rd_en, we;
    logic [AW-1:0]   rd_addr, waddr;
    logic [DW-1:0]   wdata;

    function automatic logic dim_bad(input logic [DIMW-1:0] d);
        return (d == '0) || (int'(d) > MAX_DIM);
    endfunction

    function automatic logic [CW-1:0] area(input logic [DIMW-1:0] m, input logic [DIMW-1:0] n);
        return CW'(m) * CW'(n);
    endfunction

    // Row-major linear index of element (r, c) in a matrix with ncols columns.
    function automatic logic [CW-1:0] lin(input logic [DIMW-1:0] r, input logic [DIMW-1:0] c,
                                          input logic [DIMW-1:0] ncols);
        return CW'(r) * CW'(ncols) + CW'(c);
    endfunction

    function automatic logic [DW-1:0] add_wrap(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a + b;
    endfunction

    function automatic logic [DW-1:0] mul_wrap(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a * b;
    endfunction

    always_comb begin
        chk_err = 1'b0;
        rm      = m1_q;
        rn      = n1_q;
        unique case (op_q)
            OP_TRN: begin
                chk_err = dim_bad(m1_q) || dim_bad(n1_q);
                rm      = n1_q;
                rn      = m1_q;
            end
            OP_SMUL: chk_err = dim_bad(m1_q) || dim_bad(n1_q);
            OP_ADD:  chk_err = dim_bad(m1_q) || dim_bad(n1_q) || dim_bad(m2_q) || dim_bad(n2_q)
                               || (m1_q != m2_q) || (n1_q != n2_q);
            OP_MMUL: begin
                chk_err = dim_bad(m1_q) || dim_bad(n1_q) || dim_bad(m2_q) || dim_bad(n2_q)
                          || (n1_q != m2_q);
                rn      = n2_q;
            end
            default: chk_err = 1'b1;
        endcase
    end

    // Datapath: one result element (or one MAC step for multiply) per CALC cycle.
    always_comb begin
        prod    = mul_wrap(buf_a[lin(row_q, k_q, n1_q)], buf_b[lin(k_q, col_q, n2_q)]);
        acc_nx  = add_wrap((k_q == '0) ? '0 : acc_q, prod);
        last_k  = (k_q == n1_q - D_ONE);
        unique case (op_q)
            OP_TRN:  elem_val = buf_a[lin(col_q, row_q, n1_q)];
            OP_ADD:  elem_val = add_wrap(buf_a[cnt_q], buf_b[cnt_q]);
            OP_SMUL: elem_val = mul_wrap(buf_a[cnt_q], scalar_q);
            default: elem_val = acc_nx;
        endcase
        calc_wr = (state_q == S_CALC) && ((op_q != OP_MMUL) || last_k);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        r_addr_d = r_addr_q;
        m1_d     = m1_q;
        n1_d     = n1_q;
        m2_d     = m2_q;
        n2_d     = n2_q;
        scalar_d = scalar_q;
        err_d    = err_q;
        res_m_d  = res_m_q;
        res_n_d  = res_n_q;
        na_d     = na_q;
        nb_d     = nb_q;
        nr_d     = nr_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    op_d     = bus.i_op_code;
                    a_addr_d = bus.i_op1_addr;
                    m1_d     = bus.i_op1_m;
                    n1_d     = bus.i_op1_n;
                    b_addr_d = bus.i_op2_addr;
                    m2_d     = bus.i_op2_m;
                    n2_d     = bus.i_op2_n;
                    scalar_d = bus.i_scalar;
                    r_addr_d = bus.i_res_addr;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                row_d = '0;
                col_d = '0;
                k_d   = '0;
                err_d = chk_err;
                if (chk_err) begin
                    res_m_d = '0;
                    res_n_d = '0;
                    state_d = S_DONE;
                end else begin
                    res_m_d = rm;
                    res_n_d = rn;
                    na_d    = area(m1_q, n1_q);
                    nb_d    = area(m2_q, n2_q);
                    nr_d    = area(rm, rn);
                    state_d = S_LOAD_A;
                end
            end
            // The last LOAD cycle issues no read; it only captures the final word.
            S_LOAD_A: begin
                if (cnt_q == na_q) begin
                    cnt_d   = '0;
                    state_d = ((op_q == OP_ADD) || (op_q == OP_MMUL)) ? S_LOAD_B : S_CALC;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = a_addr_q + AW'(cnt_q);
                    cnt_d   = cnt_q + C_ONE;
                end
            end
            S_LOAD_B: begin
                if (cnt_q == nb_q) begin
                    cnt_d   = '0;
                    state_d = S_CALC;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = b_addr_q + AW'(cnt_q);
                    cnt_d   = cnt_q + C_ONE;
                end
            end
            S_CALC: begin
                if ((op_q == OP_MMUL) && !last_k) begin
                    k_d = k_q + D_ONE;
                end else begin
                    k_d = '0;
                    if (col_q == res_n_q - D_ONE) begin
                        col_d = '0;
                        row_d = row_q + D_ONE;
                    end else begin
                        col_d = col_q + D_ONE;
                    end
                    if (cnt_q == nr_q - C_ONE) begin
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            S_WRITE: begin
                we    = 1'b1;
                waddr = r_addr_q + AW'(cnt_q);
                wdata = buf_r[cnt_q];
                if (cnt_q == nr_q - C_ONE) state_d = S_DONE;
                else cnt_d = cnt_q + C_ONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            r_addr_q <= '0;
            m1_q     <= '0;
            n1_q     <= '0;
            m2_q     <= '0;
            n2_q     <= '0;
            scalar_q <= '0;
            err_q    <= 1'b0;
            res_m_q  <= '0;
            res_n_q  <= '0;
            na_q     <= '0;
            nb_q     <= '0;
            nr_q     <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            r_addr_q <= r_addr_d;
            m1_q     <= m1_d;
            n1_q     <= n1_d;
            m2_q     <= m2_d;
            n2_q     <= n2_d;
            scalar_q <= scalar_d;
            err_q    <= err_d;
            res_m_q  <= res_m_d;
            res_n_q  <= res_n_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            nr_q     <= nr_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
        end
    end

    // Buffers and accumulator carry no reset; every use is preceded by a fresh load or clear.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOAD_A) && (cnt_q != '0)) buf_a[cnt_q - C_ONE] <= bus.i_rd_data;
        if ((state_q == S_LOAD_B) && (cnt_q != '0)) buf_b[cnt_q - C_ONE] <= bus.i_rd_data;
        if (state_q == S_CALC) acc_q <= acc_nx;
        if (calc_wr) buf_r[cnt_q] <= elem_val;
    end

    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = (state_q == S_DONE);
    assign bus.o_err     = (state_q == S_DONE) && err_q;
    assign bus.o_res_m   = res_m_q;
    assign bus.o_res_n   = res_n_q;
    assign bus.o_rd_en   = rd_en;
    assign bus.o_rd_addr = rd_addr;
    assign bus.o_we      = we;
    assign bus.o_waddr   = waddr;
    assign bus.o_wdata   = wdata;
endmodule

// File: tb/tb_matrix_calc_engine.sv
// Directed bench for matrix_calc_engine with a one-cycle-latency storage model.
module tb_matrix_calc_engine;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int DIMW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_calc_engine_if #(.DW(DW), .AW(AW), .DIMW(DIMW)) bus ();
    matrix_calc_engine #(.DW(DW), .AW(AW), .MAX_DIM(5), .DIMW(DIMW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [DW-1:0] rmem [256];
    logic [DW-1:0] wmem [256];
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    int            ovl_cnt = 0;
    logic [AW-1:0] last_waddr = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always @(posedge clk) begin
        bus.i_rd_data <= rmem[bus.o_rd_addr];
        if (bus.o_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.o_we) begin
            wmem[bus.o_waddr] <= bus.o_wdata;
            wr_cnt            <= wr_cnt + 1;
            last_waddr        <= bus.o_waddr;
        end
        if (bus.o_rd_en && bus.o_we) ovl_cnt <= ovl_cnt + 1;
    end

    // Issue one start, scramble the inputs afterwards, and wait (bounded) for o_done.
    task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a1, input logic [DIMW-1:0] m1,
                          input logic [DIMW-1:0] n1, input logic [AW-1:0] a2, input logic [DIMW-1:0] m2,
                          input logic [DIMW-1:0] n2, input logic [DW-1:0] sc, input logic [AW-1:0] ra,
                          input int poke_at, output int lat, output logic err_seen, output logic busy_ok);
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op_code = op; bus.i_op1_addr = a1; bus.i_op1_m = m1; bus.i_op1_n = n1;
        bus.i_op2_addr = a2; bus.i_op2_m = m2; bus.i_op2_n = n2; bus.i_scalar = sc; bus.i_res_addr = ra;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0; bus.i_op_code = 3'd7; bus.i_op1_addr = 8'hEE; bus.i_op1_m = '0; bus.i_op1_n = '0;
        bus.i_op2_addr = 8'hEE; bus.i_op2_m = '0; bus.i_op2_n = '0; bus.i_scalar = 32'h5A5A_5A5A;
        bus.i_res_addr = 8'hEE;
        lat = -1; err_seen = 1'b0; busy_ok = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (!bus.o_busy) busy_ok = 1'b0;
            if (bus.o_done) begin
                lat = n;
                err_seen = bus.o_err;
                break;
            end
            bus.i_start = (n == poke_at);
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_op_code = '0; bus.i_op1_addr = '0; bus.i_op1_m = '0; bus.i_op1_n = '0;
        bus.i_op2_addr = '0; bus.i_op2_m = '0; bus.i_op2_n = '0; bus.i_scalar = '0; bus.i_res_addr = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.o_busy, bus.o_done, bus.o_err} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b want 000", {bus.o_busy, bus.o_done, bus.o_err}); end
        n_cmp++; if ({bus.o_rd_en, bus.o_we} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {bus.o_rd_en, bus.o_we}); end
        n_cmp++; if ({bus.o_res_m, bus.o_res_n} !== '0) begin n_bad++; $display("FAIL reset_dims: got %0d x %0d want 0 x 0", bus.o_res_m, bus.o_res_n); end
        n_cmp++; if ({bus.o_rd_addr, bus.o_waddr, bus.o_wdata} !== '0) begin n_bad++; $display("FAIL reset_bus: got %h/%h/%h want 0", bus.o_rd_addr, bus.o_waddr, bus.o_wdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.o_busy); end
    endtask

    task automatic test_transpose();
        logic [DW-1:0] exp [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
        int lat, r0, w0; logic e, b;
        for (int i = 0; i < 6; i++) rmem[8'h10 + i] = DW'(i + 1);
        r0 = rd_cnt; w0 = wr_cnt;
        run_op(3'd0, 8'h10, 3'd2, 3'd3, 8'h00, 3'd0, 3'd0, '0, 8'h40, 0, lat, e, b);
        n_cmp++; if (lat !== 21) begin n_bad++; $display("FAIL trn_latency: got %0d want 21", lat); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL trn_err: got %b want 0", e); end
        n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL trn_busy: busy dropped before done"); end
        n_cmp++; if ({bus.o_res_m, bus.o_res_n} !== {3'd3, 3'd2}) begin n_bad++; $display("FAIL trn_dims: got %0d x %0d want 3 x 2", bus.o_res_m, bus.o_res_n); end
        n_cmp++; if (rd_cnt - r0 !== 6 || wr_cnt - w0 !== 6) begin n_bad++; $display("FAIL trn_counts: got rd %0d wr %0d want 6 6", rd_cnt - r0, wr_cnt - w0); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (wmem[8'h40 + i] !== exp[i]) begin n_bad++; $display("FAIL trn_data[%0d]: got %h want %h", i, wmem[8'h40 + i], exp[i]); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.o_busy, bus.o_done} !== 2'b00) begin n_bad++; $display("FAIL trn_after_done: got busy/done %b want 00", {bus.o_busy, bus.o_done}); end
    endtask

    task automatic test_multiply();
        logic [DW-1:0] exp [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
        int lat, r0, w0; logic e, b;
        for (int i = 0; i < 4; i++) begin
            rmem[8'h20 + i] = DW'(i + 1);
            rmem[8'h28 + i] = DW'(i + 5);
        end
        r0 = rd_cnt; w0 = wr_cnt;
        run_op(3'd3, 8'h20, 3'd2, 3'd2, 8'h28, 3'd2, 3'd2, '0, 8'h50, 0, lat, e, b);
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL mul_latency: got %0d want 24", lat); end
        n_cmp++; if ({bus.o_res_m, bus.o_res_n} !== {3'd2, 3'd2}) begin n_bad++; $display("FAIL mul_dims: got %0d x %0d want 2 x 2", bus.o_res_m, bus.o_res_n); end
        n_cmp++; if (rd_cnt - r0 !== 8 || wr_cnt - w0 !== 4) begin n_bad++; $display("FAIL mul_counts: got rd %0d wr %0d want 8 4", rd_cnt - r0, wr_cnt - w0); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wmem[8'h50 + i] !== exp[i]) begin n_bad++; $display("FAIL mul_data[%0d]: got %0d want %0d", i, wmem[8'h50 + i], exp[i]); end
        end
    endtask

    task automatic test_scalar_overflow();
        int lat; logic e, b;
        rmem[8'h30] = 32'hFFFF_FFFF;
        rmem[8'h31] = 32'd3;
        run_op(3'd2, 8'h30, 3'd1, 3'd2, 8'h00, 3'd0, 3'd0, 32'd2, 8'h60, 0, lat, e, b);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL smul_latency: got %0d want 9", lat); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL smul_err: got %b want 0", e); end
        n_cmp++; if (wmem[8'h60] !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL smul_data0: got %h want fffffffe", wmem[8'h60]); end
        n_cmp++; if (wmem[8'h61] !== 32'd6) begin n_bad++; $display("FAIL smul_data1: got %h want 6", wmem[8'h61]); end
        n_cmp++; if ({bus.o_res_m, bus.o_res_n} !== {3'd1, 3'd2}) begin n_bad++; $display("FAIL smul_dims: got %0d x %0d want 1 x 2", bus.o_res_m, bus.o_res_n); end
    endtask

    task automatic test_errors();
        logic [2:0]      e_op [5] = '{3'd1, 3'd7, 3'd3, 3'd0, 3'd2};
        logic [DIMW-1:0] e_m1 [5] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd6};
        logic [DIMW-1:0] e_n1 [5] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd1};
        logic [DIMW-1:0] e_m2 [5] = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd1};
        logic [DIMW-1:0] e_n2 [5] = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd1};
        int lat, r0, w0; logic e, b;
        for (int t = 0; t < 5; t++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            run_op(e_op[t], 8'h10, e_m1[t], e_n1[t], 8'h20, e_m2[t], e_n2[t], 32'd1, 8'h70, 0, lat, e, b);
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL err%0d_latency: got %0d want 2", t, lat); end
            n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err%0d_flag: got %b want 1", t, e); end
            n_cmp++; if (rd_cnt != r0 || wr_cnt != w0) begin n_bad++; $display("FAIL err%0d_access: got rd %0d wr %0d want 0 0", t, rd_cnt - r0, wr_cnt - w0); end
            n_cmp++; if ({bus.o_res_m, bus.o_res_n} !== '0) begin n_bad++; $display("FAIL err%0d_dims: got %0d x %0d want 0 x 0", t, bus.o_res_m, bus.o_res_n); end
        end
    endtask

    task automatic test_max_wrap();
        int lat, w0; logic e, b; logic [AW-1:0] a; logic [DW-1:0] want;
        for (int i = 0; i < 25; i++) begin
            rmem[8'h70 + i] = DW'(i + 1);
            rmem[8'hA0 + i] = 32'hFFFF_FFF0 + DW'(i);
        end
        w0 = wr_cnt;
        run_op(3'd1, 8'h70, 3'd5, 3'd5, 8'hA0, 3'd5, 3'd5, '0, 8'hF0, 10, lat, e, b);
        n_cmp++; if (lat !== 104) begin n_bad++; $display("FAIL max_latency: got %0d want 104", lat); end
        n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL max_busy: busy dropped before done"); end
        n_cmp++; if (wr_cnt - w0 !== 25) begin n_bad++; $display("FAIL max_writes: got %0d want 25", wr_cnt - w0); end
        n_cmp++; if (last_waddr !== 8'h08) begin n_bad++; $display("FAIL max_last_addr: got %h want 08", last_waddr); end
        for (int i = 0; i < 25; i++) begin
            a = 8'hF0 + AW'(i);
            want = DW'(2 * i) - 32'd15;
            n_cmp++; if (wmem[a] !== want) begin n_bad++; $display("FAIL max_data[%0d]: got %h want %h", i, wmem[a], want); end
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if ({bus.o_busy, bus.o_done} !== 2'b00) begin n_bad++; $display("FAIL max_no_restart: got busy/done %b want 00", {bus.o_busy, bus.o_done}); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [DW-1:0] exp [6] = '{32'd1, 32'd4, 32'd2, 32'd5, 32'd3, 32'd6};
        int lat, dones; logic e, b;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_op_code = 3'd0; bus.i_op1_addr = 8'h10; bus.i_op1_m = 3'd2; bus.i_op1_n = 3'd3;
        bus.i_res_addr = 8'h90;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.o_rd_en !== 1'b1) begin n_bad++; $display("FAIL mid_in_load: got rd_en %b want 1", bus.o_rd_en); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.o_busy, bus.o_rd_en, bus.o_we, bus.o_done, bus.o_err} !== 5'b0) begin n_bad++; $display("FAIL mid_reset_outputs: got %b want 00000", {bus.o_busy, bus.o_rd_en, bus.o_we, bus.o_done, bus.o_err}); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.o_done || bus.o_busy) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_no_completion: got %0d active cycles want 0", dones); end
        run_op(3'd0, 8'h10, 3'd2, 3'd3, 8'h00, 3'd0, 3'd0, '0, 8'h48, 0, lat, e, b);
        n_cmp++; if (lat !== 21) begin n_bad++; $display("FAIL mid_restart_latency: got %0d want 21", lat); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (wmem[8'h48 + i] !== exp[i]) begin n_bad++; $display("FAIL mid_restart_data[%0d]: got %h want %h", i, wmem[8'h48 + i], exp[i]); end
        end
        n_cmp++; if (ovl_cnt !== 0) begin n_bad++; $display("FAIL rd_we_overlap: got %0d cycles want 0", ovl_cnt); end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_multiply();
        test_scalar_overflow();
        test_errors();
        test_max_wrap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/matrix_calc_engine.md
Name: matrix_calc_engine

Overview:
Parametrised matrix arithmetic engine that sits between the top-level control FSM and the matrix storage.
- Latches operand descriptors on a start pulse and validates dimensions and operation.
- Loads operands into internal buffers through the storage read port, computes, and writes results row-major through the storage write mux.
- Compared with the earlier core, it adds generic data/address width, a configurable maximum dimension, a separate scalar input, error reporting, a busy flag and cycle-exact latency.

Parameters:
DW, 32, data word width (element and scalar)
AW, 8, storage address width
MAX_DIM, 5, maximum rows/cols per matrix; buffers hold MAX_DIM*MAX_DIM words each
DIMW, 3, dimension field width; must satisfy 2^DIMW > MAX_DIM

Ports:
clk  in  1  system clock
rst  in  1  reset
i_start  in  1  start pulse, sampled only in IDLE
i_op_code  in  3  000 transpose, 001 add, 010 scalar multiply, 011 matrix multiply; others illegal
i_op1_addr  in  AW  operand A base address
i_op1_m, i_op1_n  in  DIMW  operand A rows, cols
i_op2_addr  in  AW  operand B base address
i_op2_m, i_op2_n  in  DIMW  operand B rows, cols
i_scalar  in  DW  scalar for op 010
i_res_addr  in  AW  result base address
o_busy  out  1  high from cycle after accepted start through DONE cycle
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse coincident with o_done on rejected operation
o_res_m, o_res_n  out  DIMW  result dimensions, valid with o_done, held until next accepted start
o_rd_en  out  1  read request
o_rd_addr  out  AW  read address; i_rd_data valid exactly one cycle after o_rd_en
i_rd_data  in  DW  storage read data
o_we  out  1  write enable
o_waddr  out  AW  write address
o_wdata  out  DW  write data

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset, all outputs are 0, state is IDLE, and latched descriptors are 0. Buffer contents are don't-care.
- States: IDLE -> CHECK -> LOAD_A -> [LOAD_B] -> CALC -> WRITE -> DONE -> IDLE. CHECK goes directly to DONE on error.
- IDLE: i_start=1 latches all operand inputs and i_op_code, then moves to CHECK. Input changes after this are ignored. i_start outside IDLE is ignored.
- CHECK (1 cycle): error if any of the following hold:
  - op code illegal;
  - any used dimension is 0 or greater than MAX_DIM (A always; B for 001/011);
  - 001 with (m1!=m2 or n1!=n2);
  - 011 with n1!=m2.
  On error: no reads, no writes, o_done=o_err=1 in the DONE cycle, o_res_m/n=0.
- LOAD_A: nA=m1*n1 reads, one per cycle, at i_op1_addr+i (i=0..nA-1, row-major). Capture in the cycle after each read. State lasts nA+1 cycles.
- LOAD_B (001/011 only): same procedure from i_op2_addr, nB+1 cycles.
- Result dimensions: transpose n1 x m1; add/scalar m1 x n1; multiply m1 x n2. nR = res_m*res_n.
- CALC:
  - 000/001/010: one result element per cycle, nR cycles.
  - 011: one MAC per cycle, k=0..n1-1 per element; accumulator cleared at each element start; nR*n1 cycles.
- Arithmetic: modulo 2^DW; adds wrap; products keep the low DW bits.
- WRITE: nR cycles with o_we=1. Element i (row-major over result dims) goes to i_res_addr+i.
- Address wrap: all address sums wrap modulo 2^AW.
- o_rd_en and o_we are never asserted simultaneously, and never outside LOAD/WRITE.
- DONE: 1 cycle, o_done=1, then IDLE. o_busy drops in the IDLE cycle.
- Latency: start sampled at cycle T gives o_done at T+2+(nA+1)+[nB+1]+C+nR, where C is the CALC length.
- Reset mid-operation: immediate return to IDLE, all strobes deasserted, no partial completion pulse.

Test Plan:
- Transpose: A=2x3 {1..6} at 0x10, res 0x40, start at T -> writes 1,4,2,5,3,6 at 0x40..0x45; o_res_m=3, o_res_n=2; o_done at T+21.
- Multiply: A={1,2,3,4}, B={5,6,7,8} (2x2) -> writes 19,22,43,50; o_done at T+2+5+5+8+4=T+24.
- Scalar overflow: A=1x2 {0xFFFFFFFF, 3}, i_scalar=2 -> writes 0xFFFFFFFE, 6.
- Error: op 001 with A 2x2, B 2x3 -> o_done=o_err=1 at T+2; o_rd_en and o_we never asserted; op 111 behaves identically.
- Max size and wrap: 5x5 add with i_res_addr=0xF0 -> 25 writes, last at 0x08; o_busy high throughout; i_start pulses while busy are ignored.
- Reset mid-LOAD_A: rst pulse -> outputs 0 within the same cycle. A fresh start afterwards completes correctly with the normal latency.
